// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run controller.
package core_run_pkg;

   localparam int unsigned WIN_LEN_W          = 9;
   localparam logic [15:0] MAX_CYCLES_DEFAULT = 16'd40000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/core_run_ctrl.sv
// Run controller: loads operands with the core held in reset, runs the core until done or
// timeout, then streams a result window of data memory back out.
module core_run_ctrl
   import core_run_pkg::*;
#(
   parameter int unsigned   CW         = 16,
   parameter logic [CW-1:0] MAX_CYCLES = CW'(MAX_CYCLES_DEFAULT)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic [7:0]           load_base_i,
   input  logic [WIN_LEN_W-1:0] load_len_i,
   input  logic [7:0]           res_base_i,
   input  logic [WIN_LEN_W-1:0] res_len_i,
   input  logic                 in_valid_i,
   input  logic [7:0]           in_data_i,
   output logic                 in_ready_o,
   output logic                 out_valid_o,
   output logic [7:0]           out_data_o,
   input  logic                 out_ready_i,
   output logic                 core_reset_o,
   input  logic                 core_done_i,
   output logic                 mem_sel_o,
   output logic [7:0]           mem_addr_o,
   output logic [7:0]           mem_wdata_o,
   output logic                 mem_we_o,
   input  logic [7:0]           mem_rdata_i,
   output logic                 busy_o,
   output logic                 timeout_o,
   output logic [CW-1:0]        cycles_o
);

   state_t               r_state,     w_state_nxt;
   logic [WIN_LEN_W-1:0] r_idx,       w_idx_nxt;
   logic [7:0]           r_load_base, w_load_base_nxt;
   logic [WIN_LEN_W-1:0] r_load_len,  w_load_len_nxt;
   logic [7:0]           r_res_base,  w_res_base_nxt;
   logic [WIN_LEN_W-1:0] r_res_len,   w_res_len_nxt;
   logic [CW-1:0]        r_cycles,    w_cycles_nxt;
   logic                 r_timeout,   w_timeout_nxt;
   logic [CW-1:0]        w_cycles_inc;
   state_t               w_run_exit;

   // Saturating increment keeps the counter from ever wrapping.
   assign w_cycles_inc = (r_cycles >= MAX_CYCLES) ? MAX_CYCLES : r_cycles + CW'(1);
   assign w_run_exit   = (r_res_len != '0) ? DRAIN : IDLE;

   assign busy_o    = (r_state != IDLE);
   assign timeout_o = r_timeout;
   assign cycles_o  = r_cycles;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_load_base <= '0;
         r_load_len  <= '0;
         r_res_base  <= '0;
         r_res_len   <= '0;
         r_cycles    <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_load_base <= w_load_base_nxt;
         r_load_len  <= w_load_len_nxt;
         r_res_base  <= w_res_base_nxt;
         r_res_len   <= w_res_len_nxt;
         r_cycles    <= w_cycles_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_load_base_nxt = r_load_base;
      w_load_len_nxt  = r_load_len;
      w_res_base_nxt  = r_res_base;
      w_res_len_nxt   = r_res_len;
      w_cycles_nxt    = r_cycles;
      w_timeout_nxt   = r_timeout;
      core_reset_o    = 1'b1;
      mem_sel_o       = 1'b0;
      in_ready_o      = 1'b0;
      out_valid_o     = 1'b0;
      out_data_o      = '0;
      mem_we_o        = 1'b0;
      mem_addr_o      = '0;
      mem_wdata_o     = '0;

      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               w_load_base_nxt = load_base_i;
               w_load_len_nxt  = load_len_i;
               w_res_base_nxt  = res_base_i;
               w_res_len_nxt   = res_len_i;
               w_idx_nxt       = '0;
               w_cycles_nxt    = '0;
               w_timeout_nxt   = 1'b0;
               w_state_nxt     = (load_len_i != '0) ? LOAD : RUN;
            end
         end

         LOAD: begin
            mem_sel_o   = 1'b1;
            in_ready_o  = 1'b1;
            mem_we_o    = in_valid_i;
            mem_addr_o  = r_load_base + r_idx[7:0];
            mem_wdata_o = in_data_i;
            if (in_valid_i) begin
               if (r_idx == r_load_len - WIN_LEN_W'(1)) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = RUN;
               end else begin
                  w_idx_nxt = r_idx + WIN_LEN_W'(1);
               end
            end
         end

         RUN: begin
            core_reset_o = 1'b0;
            w_cycles_nxt = w_cycles_inc;
            // Done has priority over a limit hit in the same cycle.
            if (core_done_i) begin
               w_idx_nxt   = '0;
               w_state_nxt = w_run_exit;
            end else if (w_cycles_inc >= MAX_CYCLES) begin
               w_timeout_nxt = 1'b1;
               w_idx_nxt     = '0;
               w_state_nxt   = w_run_exit;
            end
         end

         DRAIN: begin
            mem_sel_o   = 1'b1;
            out_valid_o = 1'b1;
            mem_addr_o  = r_res_base + r_idx[7:0];
            out_data_o  = mem_rdata_i;
            if (out_ready_i) begin
               if (r_idx == r_res_len - WIN_LEN_W'(1)) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_idx_nxt = r_idx + WIN_LEN_W'(1);
               end
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: table rows, directed corner sequences and random transactions
// checked against a transaction-level model of memory, stream and cycle count.
module tb_core_run_ctrl;
   localparam int MAXC = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_i;
   logic [7:0] load_base_i, res_base_i;
   logic [8:0] load_len_i, res_len_i;
   logic       in_valid_i, in_ready_o;
   logic [7:0] in_data_i;
   logic       out_valid_o, out_ready_i;
   logic [7:0] out_data_o;
   logic       core_reset_o, core_done_i;
   logic       mem_sel_o, mem_we_o;
   logic [7:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic       busy_o, timeout_o;
   logic [15:0] cycles_o;

   core_run_ctrl #(.CW(16), .MAX_CYCLES(16'(MAXC))) dut (
      .clk(clk), .reset(reset), .start_i(start_i),
      .load_base_i(load_base_i), .load_len_i(load_len_i),
      .res_base_i(res_base_i), .res_len_i(res_len_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
      .core_reset_o(core_reset_o), .core_done_i(core_done_i),
      .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .timeout_o(timeout_o), .cycles_o(cycles_o)
   );

   always #5 clk = ~clk;

   // Data memory with a bench-side preload port; reads are combinational.
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic       tb_we = 1'b0;
   logic [7:0] tb_addr = '0, tb_wdata = '0;
   always @(posedge clk) begin
      if (tb_we) mem[tb_addr] <= tb_wdata;
      else if (mem_sel_o && mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
   end
   assign mem_rdata_i = mem[mem_addr_o];

   // Core model: raises done in its done_at-th cycle out of reset (0 = never).
   int done_at = 0;
   int run_cnt = 0;
   always @(posedge clk) run_cnt <= core_reset_o ? 0 : run_cnt + 1;
   assign core_done_i = !core_reset_o && (done_at != 0) && (run_cnt + 1 == done_at);

   logic [15:0] got_wr[$];
   logic [7:0]  got_out[$];
   bit          saw_ov;
   always @(negedge clk) begin
      if (mem_sel_o && mem_we_o) got_wr.push_back({mem_addr_o, mem_wdata_o});
      if (out_valid_o) saw_ov = 1'b1;
      if (out_valid_o && out_ready_i) got_out.push_back(out_data_o);
   end

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   task automatic tb_write(input logic [7:0] a, input logic [7:0] d);
      tb_we = 1'b1; tb_addr = a; tb_wdata = d;
      @(posedge clk) #1;
      tb_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic start_txn(input logic [7:0] lb, input logic [8:0] ll, input logic [7:0] rb,
                            input logic [8:0] rl);
      load_base_i = lb; load_len_i = ll; res_base_i = rb; res_len_i = rl;
      start_i = 1'b1;
      @(posedge clk) #1;
      start_i = 1'b0;
   endtask

   task automatic run_txn(input logic [7:0] lb, input logic [8:0] ll, input logic [7:0] rb,
                          input logic [8:0] rl, input int da, input bit gaps,
                          output logic [31:0] got_cyc, output logic [31:0] got_to);
      logic [7:0]  bytes[$];
      logic [15:0] exp_wr[$];
      logic [7:0]  exp_out[$];
      int n, cyc;
      for (int i = 0; i < int'(ll); i++) begin
         bytes.push_back(8'($urandom));
         exp_wr.push_back({8'(lb + 8'(i)), bytes[i]});
         ref_mem[8'(lb + 8'(i))] = bytes[i];
      end
      for (int i = 0; i < int'(rl); i++) exp_out.push_back(ref_mem[8'(rb + 8'(i))]);
      got_wr.delete(); got_out.delete(); saw_ov = 1'b0; done_at = da;
      start_txn(lb, ll, rb, rl);
      n = 0; cyc = 0;
      while (busy_o && cyc < 4000) begin
         in_valid_i  = (n < int'(ll)) && (!gaps || $urandom_range(0, 2) != 0);
         in_data_i   = (n < int'(ll)) ? bytes[n] : 8'h00;
         out_ready_i = !gaps || $urandom_range(0, 2) != 0;
         @(negedge clk);
         if (in_valid_i && in_ready_o) n++;
         @(posedge clk) #1;
         cyc++;
      end
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      chk("txn_returns_idle", 32'(busy_o), 32'd0);
      got_cyc = 32'(cycles_o);
      got_to  = 32'(timeout_o);
      chk("write_count", 32'(got_wr.size()), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
         chk("write_addr_data", 32'(got_wr[i]), 32'(exp_wr[i]));
      chk("drain_count", 32'(got_out.size()), 32'(exp_out.size()));
      for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
         chk("drain_data", 32'(got_out[i]), 32'(exp_out[i]));
      if (rl == 9'd0) chk("no_out_valid", 32'(saw_ov), 32'd0);
   endtask

   typedef struct {
      logic [7:0] lb;
      logic [8:0] ll;
      logic [7:0] rb;
      logic [8:0] rl;
      int         da;
      int         exp_cyc;
      int         exp_to;
   } vec_t;

   initial begin
      vec_t        tbl[7];
      logic [31:0] gc, gt;
      logic [7:0]  b[4];
      int          k;

      tbl[0] = '{8'h10, 9'd3,   8'h20, 9'd2,   5, 5, 0};
      tbl[1] = '{8'h30, 9'd2,   8'h30, 9'd2,   0, 8, 1};
      tbl[2] = '{8'hFE, 9'd4,   8'hFE, 9'd4,   3, 3, 0};
      tbl[3] = '{8'h00, 9'd0,   8'h00, 9'd0,   2, 2, 0};
      tbl[4] = '{8'h40, 9'd1,   8'h00, 9'd1,   8, 8, 0};
      tbl[5] = '{8'h00, 9'd256, 8'h80, 9'd256, 1, 1, 0};
      tbl[6] = '{8'h50, 9'd0,   8'h10, 9'd3,   9, 8, 1};

      reset = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
      load_base_i = '0; load_len_i = '0; res_base_i = '0; res_len_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_core_reset", 32'(core_reset_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_mem_sel", 32'(mem_sel_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      chk("rst_cycles", 32'(cycles_o), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 256; i++) tb_write(8'(i), 8'($urandom));

      // Basic load timing, done in 5th RUN cycle, drain under backpressure.
      tb_write(8'h20, 8'h5A);
      tb_write(8'h21, 8'hC6);
      b[0] = 8'hA1; b[1] = 8'hB2; b[2] = 8'hC3;
      done_at = 5;
      in_valid_i = 1'b1; in_data_i = b[0];
      start_txn(8'h10, 9'd3, 8'h20, 9'd2);
      for (int i = 0; i < 3; i++) begin
         in_data_i = b[i];
         @(negedge clk);
         chk("basic_we", 32'(mem_we_o), 32'd1);
         chk("basic_addr", 32'(mem_addr_o), 32'(8'h10 + 8'(i)));
         chk("basic_wdata", 32'(mem_wdata_o), 32'(b[i]));
         @(posedge clk) #1;
         ref_mem[8'(8'h10 + 8'(i))] = b[i];
      end
      in_valid_i = 1'b0;
      @(negedge clk);
      chk("run_entry_core_reset", 32'(core_reset_o), 32'd0);
      k = 0;
      while (!out_valid_o && k < 100) begin
         @(posedge clk) #1;
         k++;
      end
      chk("done_cycles", 32'(cycles_o), 32'd5);
      chk("done_timeout", 32'(timeout_o), 32'd0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid_o), 32'd1);
         chk("bp_data_hold", 32'(out_data_o), 32'h5A);
         @(posedge clk) #1;
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      chk("drain_first", 32'(out_data_o), 32'h5A);
      @(posedge clk) #1;
      @(negedge clk);
      chk("drain_second", 32'(out_data_o), 32'hC6);
      @(posedge clk) #1;
      out_ready_i = 1'b0;
      chk("drain_done_idle", 32'(busy_o), 32'd0);

      // Reset asserted after the 2nd of 4 load handshakes.
      b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
      done_at = 0;
      start_txn(8'h60, 9'd4, 8'h00, 9'd0);
      in_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data_i = b[i];
         @(posedge clk) #1;
      end
      in_data_i = b[2];
      reset = 1'b0;
      #1;
      chk("abort_core_reset", 32'(core_reset_o), 32'd1);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_mem_we", 32'(mem_we_o), 32'd0);
      @(posedge clk) #1;
      @(posedge clk) #1;
      in_valid_i = 1'b0;
      reset = 1'b1;
      chk("abort_written_1", 32'(mem[8'h61]), 32'h22);
      chk("abort_no_write_2", 32'(mem[8'h62]), 32'(ref_mem[8'h62]));
      chk("abort_no_write_3", 32'(mem[8'h63]), 32'(ref_mem[8'h63]));
      ref_mem[8'h60] = b[0];
      ref_mem[8'h61] = b[1];

      for (int t = 0; t < 7; t++) begin
         run_txn(tbl[t].lb, tbl[t].ll, tbl[t].rb, tbl[t].rl, tbl[t].da, 1'b0, gc, gt);
         chk("tbl_cycles", gc, 32'(tbl[t].exp_cyc));
         chk("tbl_timeout", gt, 32'(tbl[t].exp_to));
      end

      for (int t = 0; t < 24; t++) begin
         logic [7:0] lb, rb;
         logic [8:0] ll, rl;
         int da, ecyc, eto;
         lb = 8'($urandom); rb = 8'($urandom);
         ll = 9'($urandom_range(0, 40)); rl = 9'($urandom_range(0, 40));
         da = $urandom_range(0, MAXC + 2);
         eto  = (da == 0 || da > MAXC) ? 1 : 0;
         ecyc = eto ? MAXC : da;
         run_txn(lb, ll, rb, rl, da, 1'b1, gc, gt);
         chk("rnd_cycles", gc, 32'(ecyc));
         chk("rnd_timeout", gt, 32'(eto));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
